// File: rtl/usb_packet_tx_pkg.sv
// Shared types and constants for the USB packet transmitter: PID codes, FSM states,
// CRC16 constants and PID classification helpers.
package usb_packet_tx_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'b0000,
    PID_OUT   = 4'b0001,
    PID_ACK   = 4'b0010,
    PID_DATA0 = 4'b0011,
    PID_PING  = 4'b0100,
    PID_SOF   = 4'b0101,
    PID_NYET  = 4'b0110,
    PID_DATA2 = 4'b0111,
    PID_SPLIT = 4'b1000,
    PID_IN    = 4'b1001,
    PID_NAK   = 4'b1010,
    PID_DATA1 = 4'b1011,
    PID_PRE   = 4'b1100,
    PID_SETUP = 4'b1101,
    PID_STALL = 4'b1110,
    PID_MDATA = 4'b1111
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } state_t;

  // Reflected form of x^16+x^15+x^2+1, shifted LSB-first.
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int          BYTE_CNT_W = 7;

  function automatic logic is_legal_tx_pid(input pid_t p);
    return p inside {PID_ACK, PID_NAK, PID_STALL, PID_DATA0, PID_DATA1};
  endfunction

  function automatic logic is_data_pid(input pid_t p);
    return p inside {PID_DATA0, PID_DATA1};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational byte-wise USB CRC16 update, bit 0 of the data byte first.
module usb_crc16
  import usb_packet_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // NOTE: blocking assignments let the eight bit-steps chain inside one combinational
  // evaluation; sequential state elsewhere uses non-blocking assignments only.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC16_POLY;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/usb_packet_tx.sv
// USB packet transmitter: sends PID, optional payload and complemented CRC16 to the SIE
// one byte per tx_ready pulse, flagging illegal PIDs and payload underruns.
module usb_packet_tx
  import usb_packet_tx_pkg::*;
#(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  pid_t       pid,
  input  logic       no_payload,
  input  logic [7:0] payload,
  input  logic       payload_valid,
  input  logic       payload_last,
  output logic       payload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [BYTE_CNT_W-1:0] CNT_MAX = BYTE_CNT_W'(MAX_LEN);

  state_t                state, state_nxt;
  logic [7:0]            tx_data_nxt;
  logic                  tx_valid_nxt;
  logic [15:0]           crc, crc_nxt, crc_upd;
  logic [BYTE_CNT_W-1:0] cnt, cnt_nxt;
  logic                  is_data, is_data_nxt;
  logic                  skip_payload, skip_payload_nxt;
  logic                  last, last_nxt;
  logic                  done_nxt, error_nxt;
  logic                  need_byte;
  logic                  byte_is_last;
  logic [3:0]            pid_bits;

  assign pid_bits     = pid;
  assign busy         = (state != ST_IDLE);
  assign byte_is_last = last || (cnt == CNT_MAX);

  usb_crc16 u_crc16 (
    .crc_in  (crc),
    .data    (payload),
    .crc_out (crc_upd)
  );

  // NOTE: every output of this block gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt        = state;
    tx_data_nxt      = tx_data;
    tx_valid_nxt     = tx_valid;
    crc_nxt          = crc;
    cnt_nxt          = cnt;
    is_data_nxt      = is_data;
    skip_payload_nxt = skip_payload;
    last_nxt         = last;
    done_nxt         = 1'b0;
    error_nxt        = 1'b0;
    need_byte        = 1'b0;
    payload_ready    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_tx_pid(pid)) begin
            state_nxt        = ST_PID;
            tx_valid_nxt     = 1'b1;
            tx_data_nxt      = {~pid_bits, pid_bits};
            crc_nxt          = CRC16_INIT;
            cnt_nxt          = '0;
            is_data_nxt      = is_data_pid(pid);
            skip_payload_nxt = no_payload;
            last_nxt         = 1'b0;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      ST_PID: begin
        if (tx_ready) begin
          if (!is_data) begin
            state_nxt    = ST_IDLE;
            tx_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else if (skip_payload) begin
            state_nxt   = ST_CRC_LO;
            tx_data_nxt = ~crc[7:0];
          end else begin
            need_byte = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tx_ready) begin
          if (byte_is_last) begin
            state_nxt   = ST_CRC_LO;
            tx_data_nxt = ~crc[7:0];
          end else begin
            need_byte = 1'b1;
          end
        end
      end
      ST_CRC_LO: begin
        if (tx_ready) begin
          state_nxt   = ST_CRC_HI;
          tx_data_nxt = ~crc[15:8];
        end
      end
      ST_CRC_HI: begin
        if (tx_ready) begin
          state_nxt    = ST_IDLE;
          tx_valid_nxt = 1'b0;
          done_nxt     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A byte is owed to the SIE: take it from the endpoint, or abort on underrun.
    if (need_byte) begin
      if (payload_valid) begin
        payload_ready = 1'b1;
        state_nxt     = ST_DATA;
        tx_data_nxt   = payload;
        crc_nxt       = crc_upd;
        cnt_nxt       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        last_nxt      = payload_last;
      end else begin
        state_nxt    = ST_IDLE;
        tx_valid_nxt = 1'b0;
        error_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      crc          <= CRC16_INIT;
      cnt          <= '0;
      is_data      <= 1'b0;
      skip_payload <= 1'b0;
      last         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx_valid     <= tx_valid_nxt;
      tx_data      <= tx_data_nxt;
      crc          <= crc_nxt;
      cnt          <= cnt_nxt;
      is_data      <= is_data_nxt;
      skip_payload <= skip_payload_nxt;
      last         <= last_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
    end
  end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Self-checking bench for usb_packet_tx: directed and randomized packets against a
// byte-stream reference model built from the USB packet rules.
module tb_usb_packet_tx;
  import usb_packet_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  pid_t       pid;
  logic       no_payload;
  logic [7:0] payload;
  logic       payload_valid;
  logic       payload_last;
  logic       payload_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pay [0:79];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] lit_q [$];
  int         exp_done, exp_err, exp_pr;

  usb_packet_tx #(.MAX_LEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pid           (pid),
    .no_payload    (no_payload),
    .payload       (payload),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .payload_ready (payload_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [3:0] p);
    return p == 4'h2 || p == 4'hA || p == 4'hE || p == 4'h3 || p == 4'hB;
  endfunction

  function automatic bit m_data(input logic [3:0] p);
    return p == 4'h3 || p == 4'hB;
  endfunction

  // Bit-serial CRC16 (reflected poly, init all-ones) over pay[0..len-1].
  function automatic logic [15:0] m_crc(input int len);
    logic [15:0] c = 16'hFFFF;
    for (int b = 0; b < len * 8; b++) begin
      logic fb;
      fb = c[0] ^ pay[b / 8][b % 8];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic build_expected(input logic [3:0] p, input bit np, input int n, input int ur);
    int          need, avail;
    logic [15:0] c;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_pr   = 0;
    if (!m_legal(p)) begin
      exp_err = 1;
      return;
    end
    exp_q.push_back({~p, p});
    if (!m_data(p)) begin
      exp_done = 1;
    end else if (np) begin
      c = ~m_crc(0);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_done = 1;
    end else begin
      need  = (n < 64) ? n : 64;
      if (need < 1) need = 1;
      avail = (ur >= 0 && ur < n) ? ur : n;
      if (avail >= need) begin
        for (int i = 0; i < need; i++) exp_q.push_back(pay[i]);
        c = ~m_crc(need);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_done = 1;
        exp_pr   = need;
      end else begin
        for (int i = 0; i < avail; i++) exp_q.push_back(pay[i]);
        exp_err = 1;
        exp_pr  = avail;
      end
    end
  endtask

  task automatic run_packet(input string tag, input logic [3:0] p, input bit np,
                            input int n, input int ur, input bit gaps);
    int         idx = 0, pr_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int         viol = 0, mism = 0;
    bit         finished = 0, rdy, pv, prev_valid = 0, prev_rdy = 0;
    logic [7:0] prev_data = 8'h00;
    build_expected(p, np, n, ur);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; pid = pid_t'(p); no_payload = np;
    tx_ready = 1'b0; payload_valid = 1'b0; payload_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done && error) both_cnt++;
      if (prev_valid && !prev_rdy && tx_valid && tx_data !== prev_data) viol++;
      if (!busy) begin
        finished = 1;
        break;
      end
      rdy = tx_valid && (!gaps || $urandom_range(0, 2) != 0);
      if (rdy) got_q.push_back(tx_data);
      pv = (idx < n) && !(ur >= 0 && idx >= ur);
      tx_ready      = rdy;
      payload_valid = pv;
      payload       = pv ? pay[idx] : 8'($urandom);
      payload_last  = pv && (idx == n - 1);
      // Requests while busy must be ignored.
      start         = ($urandom_range(0, 3) == 0);
      pid           = pid_t'(4'($urandom_range(0, 15)));
      no_payload    = 1'($urandom_range(0, 1));
      prev_valid = tx_valid;
      prev_rdy   = rdy;
      prev_data  = tx_data;
      #1;
      if (payload_ready) begin
        pr_cnt++;
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0; tx_ready = 1'b0; payload_valid = 1'b0; payload_last = 1'b0;
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_byte_mismatches"}, mism, 0);
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_error"}, err_cnt, exp_err);
    check({tag, "_done_and_error"}, both_cnt, 0);
    check({tag, "_payload_ready"}, pr_cnt, exp_pr);
    check({tag, "_tx_data_stable"}, viol, 0);
    check({tag, "_tx_valid_low"}, 32'(tx_valid), 32'd0);
  endtask

  task automatic check_literal(input string tag);
    int mism = 0;
    check({tag, "_lit_len"}, got_q.size(), lit_q.size());
    for (int i = 0; i < got_q.size() && i < lit_q.size(); i++)
      if (got_q[i] !== lit_q[i]) mism++;
    check({tag, "_lit_bytes"}, mism, 0);
  endtask

  initial begin
    int idx;
    int err_cnt, done_cnt, valid_cnt;

    reset = 1'b0; start = 1'b0; pid = PID_ACK; no_payload = 1'b0;
    payload = 8'h00; payload_valid = 1'b1; payload_last = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_payload_ready", 32'(payload_ready), 32'd0);
    reset = 1'b1; tx_ready = 1'b0; payload_valid = 1'b0;
    repeat (2) @(negedge clk);

    run_packet("ack", 4'h2, 1'b0, 0, -1, 1'b0);
    lit_q = '{8'hD2};
    check_literal("ack");
    run_packet("nak", 4'hA, 1'b0, 0, -1, 1'b1);
    run_packet("stall", 4'hE, 1'b1, 0, -1, 1'b1);

    run_packet("data1_zlp", 4'hB, 1'b1, 0, -1, 1'b1);
    lit_q = '{8'h4B, 8'h00, 8'h00};
    check_literal("data1_zlp");

    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    run_packet("data0_123456789", 4'h3, 1'b0, 9, -1, 1'b1);
    lit_q = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'hC8, 8'hB4};
    check_literal("data0_123456789");

    run_packet("underrun", 4'h3, 1'b0, 9, 1, 1'b0);
    lit_q = '{8'hC3, 8'h31};
    check_literal("underrun");

    run_packet("setup_illegal", 4'hD, 1'b0, 4, -1, 1'b0);

    for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);
    run_packet("stream70", 4'hB, 1'b0, 70, -1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      logic [3:0] p;
      bit         np;
      int         n, ur;
      p  = 4'($urandom_range(0, 15));
      np = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(1, 70);
      ur = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);
      run_packet($sformatf("rand%0d", k), p, np, n, ur, 1'b1);
    end

    // Reset in the middle of a 64-byte DATA0 packet.
    for (int i = 0; i < 80; i++) pay[i] = 8'($urandom);
    idx = 0;
    @(negedge clk);
    start = 1'b1; pid = PID_DATA0; no_payload = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tx_ready = 1'b1; payload_valid = 1'b1; payload = pay[idx];
      payload_last = (idx == 63);
      #1;
      if (payload_ready) idx++;
      @(negedge clk);
    end
    check("midrst_busy_before", 32'(busy), 32'd1);
    check("midrst_bytes_consumed", idx, 12);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    check("midrst_payload_ready", 32'(payload_ready), 32'd0);
    reset = 1'b1;
    err_cnt = 0; done_cnt = 0; valid_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (tx_valid) valid_cnt++;
    end
    check("postrst_done", done_cnt, 0);
    check("postrst_error", err_cnt, 0);
    check("postrst_tx_valid_idle", valid_cnt, 0);
    tx_ready = 1'b0; payload_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_packet_tx.md
USB_PACKET_TX -- requirements
Module: usb_packet_tx

Interface
REQ-001 Parameter: MAX_LEN, 64, maximum payload bytes per data packet.
REQ-002 clk  input  1  system clock (24 MHz).
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-005 pid  input  pid_t  PID of the requested packet; sampled with start.
REQ-006 no_payload  input  1  marks a DATAx request as zero-length; sampled with start.
REQ-007 payload  input  8  payload byte from the endpoint.
REQ-008 payload_valid  input  1  payload byte valid.
REQ-009 payload_last  input  1  current payload byte is the final one.
REQ-010 payload_ready  output  1  payload byte consumed this cycle.
REQ-011 tx_data  output  8  byte to the SIE.
REQ-012 tx_valid  output  1  rise: SYNC, high: send data, fall: EOP.
REQ-013 tx_ready  input  1  one-cycle pulse; the SIE has taken tx_data.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a packet completes normally.
REQ-016 error  output  1  one-cycle pulse on an illegal PID or a payload underrun.

Function
REQ-017 States: IDLE, PID, DATA, CRC_LO, CRC_HI.
REQ-018 Legal PIDs are ACK, NAK, STALL, DATA0 and DATA1.
- IDLE + start + legal PID: next cycle state PID, tx_valid=1, tx_data={~pid,pid}.
- IDLE + start + any other PID: error=1 next cycle; stay IDLE; tx_valid stays 0.
REQ-019 PID state, tx_ready pulse:
- handshake PID: tx_valid=0 and done=1 next cycle; go to IDLE.
- DATAx with no_payload: go to CRC_LO.
- otherwise: consume a payload byte (see REQ-020) and go to DATA.
REQ-020 Byte consumption:
- payload_ready = tx_ready AND payload_valid, combinationally, in PID (DATAx, payload) and in DATA.
- The consumed byte is registered into tx_data for the next cycle and folded into the CRC.
REQ-021 DATA state, tx_ready pulse:
- if the byte on tx_data was last (payload_last captured with it, or byte count = MAX_LEN): go to CRC_LO with tx_data=~crc[7:0].
- otherwise: consume the next byte.
REQ-022 CRC_LO state, tx_ready pulse: tx_data=~crc[15:8]; go to CRC_HI.
REQ-023 CRC_HI state, tx_ready pulse: tx_valid=0 and done=1 next cycle; go to IDLE.
REQ-024 CRC16 arithmetic:
- polynomial x^16+x^15+x^2+1, LSB-first (reflected constant 16'hA001).
- initialised to 16'hFFFF on every start.
- updated byte-wise, bit 0 first.
- transmitted complemented, low byte first.
REQ-025 Underrun: a tx_ready pulse that requires a payload byte while payload_valid=0 → tx_valid=0 and error=1 next cycle; go to IDLE; no CRC bytes are sent.
REQ-026 Byte counter is 7 bits, cleared on start, and saturates at MAX_LEN; byte MAX_LEN is always treated as last.
REQ-027 tx_data stays stable while tx_valid=1 and no tx_ready pulse arrives; tx_ready in IDLE is ignored.
REQ-028 start while busy is ignored; there is no queueing.
REQ-029 done and error are never asserted in the same cycle.

Reset
REQ-030 With reset=0 at a clock edge, the following hold from the next cycle:
- state=IDLE, tx_valid=0, tx_data=8'h00;
- payload_ready=0, busy=0, done=0, error=0;
- byte counter=0, crc=16'hFFFF.
REQ-031 Reset asserted mid-packet drops tx_valid within one cycle (truncated packet, SIE emits EOP); no done or error pulse is generated.

Structure
REQ-032 pid_t, the CRC16 polynomial and init constants, and a legal-TX-PID function live in package types.
REQ-033 The single sub-module usb_crc16 is combinational: it takes crc_in[15:0] and a data byte and produces crc_out[15:0].
REQ-034 Expected size: 150-250 lines of RTL including usb_crc16.

Verification
REQ-035 start, pid=ACK → tx_valid=1, tx_data=8'hD2; tx_ready → tx_valid=0, done=1; payload_ready never asserted.
REQ-036 start, pid=DATA1, no_payload=1 → bytes 8'h4B, 8'h00, 8'h00, then tx_valid falls and done pulses.
REQ-037 start, pid=DATA0, payload "123456789" (8'h31..8'h39, last on 8'h39) → bytes C3 31..39 C8 B4; done=1.
REQ-038 DATA0 with payload_valid=0 at the second tx_ready → tx_valid=0, error=1, IDLE; no C8/B4-type CRC bytes appear.
REQ-039 start with pid=SETUP → error=1, tx_valid stays 0; then reset=0 during the DATA state of a 64-byte packet → tx_valid=0 next cycle, busy=0, no done.
REQ-040 A 70-byte stream with MAX_LEN=64 → exactly 64 payload_ready pulses, followed by the CRC of the first 64 bytes.
